// File: rtl/de_pkg.sv
// Shared definitions for the dice-roller sequencer: dice codes, die sizes, display codes, FSM states.
package de_pkg;

    typedef enum logic [2:0] {
        D4   = 3'd0,
        D6   = 3'd1,
        D8   = 3'd2,
        D10  = 3'd3,
        D12  = 3'd4,
        D20  = 3'd5,
        D30  = 3'd6,
        D100 = 3'd7
    } dice_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ROLLING = 2'd1,
        S_CONV    = 2'd2,
        S_RESULT  = 2'd3
    } state_t;

    localparam logic [3:0] DIG_DASH  = 4'd14;
    localparam logic [3:0] DIG_BLANK = 4'd15;

    function automatic logic [6:0] dice_n(input logic [2:0] code);
        case (dice_t'(code))
            D4:      return 7'd4;
            D6:      return 7'd6;
            D8:      return 7'd8;
            D10:     return 7'd10;
            D12:     return 7'd12;
            D20:     return 7'd20;
            D30:     return 7'd30;
            default: return 7'd100;
        endcase
    endfunction

    // Returns {cent, diz, unit} with leading zeros blanked.
    function automatic logic [11:0] blank_digits(input logic [6:0] value, input logic [3:0] b2,
                                                 input logic [3:0] b1, input logic [3:0] b0);
        logic [3:0] cent;
        logic [3:0] diz;
        cent = (value < 7'd100) ? DIG_BLANK : b2;
        diz  = (value < 7'd10)  ? DIG_BLANK : b1;
        return {cent, diz, b0};
    endfunction

    function automatic logic [11:0] bin_to_bcd(input logic [6:0] value);
        int v;
        v = int'(value);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_conv_seq.sv
// Sequential double-dabble, 7-bit binary to 3 BCD digits: one load cycle after start, then 7 shifts.
// done is high during the last shift cycle, with bcd2..bcd0 carrying the final digits in that same cycle.
module bcd_conv_seq
    import de_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       done,
    output logic [3:0] bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0
);

    logic [18:0] sr_q;
    logic [18:0] sr_adj;
    logic [18:0] sr_d;
    logic [2:0]  cnt_q;
    logic        run_q;

    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < 3; i++) begin
            if (sr_adj[7+4*i +: 4] >= 4'd5) begin
                sr_adj[7+4*i +: 4] = sr_adj[7+4*i +: 4] + 4'd3;
            end
        end
        sr_d = {sr_adj[17:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            sr_q  <= {12'd0, bin};
            cnt_q <= 3'd7;
            run_q <= 1'b1;
        end else if (run_q) begin
            sr_q  <= sr_d;
            cnt_q <= cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
                run_q <= 1'b0;
            end
        end
    end

    assign done = run_q && (cnt_q == 3'd1);
    assign bcd2 = sr_d[18:15];
    assign bcd1 = sr_d[14:11];
    assign bcd0 = sr_d[10:7];

endmodule

// File: rtl/controleur_lancer_de.sv
// Dice-roller sequencer: dice select, roll counter, BCD conversion and 4-digit scan; no backpressure.
// ROLL_ANIM_EN shows the live roll value while rolling; otherwise dashes are shown.
module controleur_lancer_de
    import de_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int MIN_ROLL = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_sel,
    input  logic       btn_roll,
    output logic [2:0] dice,
    input  logic [3:0] sep_unit,
    input  logic [3:0] sep_diz,
    input  logic [3:0] sep_cent,
    input  logic [3:0] sep_d,
    output logic [3:0] digit,
    output logic [3:0] an,
    output logic       busy,
    output logic       show_res
);

    localparam int EW = $clog2(MIN_ROLL + 1);
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [EW-1:0] MIN_E   = EW'(MIN_ROLL);
    localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);

    state_t        state_q, state_d;
    logic [2:0]    dice_q, dice_d;
    logic [6:0]    value_q, value_d;
    logic [EW-1:0] elapsed_q, elapsed_d;
    logic          sel_prev_q, roll_prev_q;
    logic          conv_start_q;
    logic [3:0]    res_unit_q, res_diz_q, res_cent_q;
    logic [PW-1:0] ps_q, ps_d;
    logic [1:0]    slot_q, slot_d;
    logic [3:0]    an_q, digit_q, digit_d;
    logic [15:0]   src;
    logic [15:0]   roll_digits;

    logic       sel_edge, roll_edge;
    logic       conv_done;
    logic [3:0] bcd2, bcd1, bcd0;

    assign sel_edge  = btn_sel & ~sel_prev_q;
    assign roll_edge = btn_roll & ~roll_prev_q;

    bcd_conv_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .start (conv_start_q),
        .bin   (value_q),
        .done  (conv_done),
        .bcd2  (bcd2),
        .bcd1  (bcd1),
        .bcd0  (bcd0)
    );

    always_comb begin
        state_d   = state_q;
        dice_d    = dice_q;
        value_d   = value_q;
        elapsed_d = elapsed_q;
        case (state_q)
            S_IDLE: begin
                if (roll_edge) begin
                    state_d   = S_ROLLING;
                    value_d   = 7'd1;
                    elapsed_d = EW'(1);
                end else if (sel_edge) begin
                    dice_d = dice_q + 3'd1;
                end
            end
            S_ROLLING: begin
                if (!btn_roll && (elapsed_q >= MIN_E)) begin
                    state_d = S_CONV;
                end else begin
                    value_d = (value_q >= dice_n(dice_q)) ? 7'd1 : value_q + 7'd1;
                    if (elapsed_q < MIN_E) begin
                        elapsed_d = elapsed_q + EW'(1);
                    end
                end
            end
            S_CONV: begin
                if (conv_done) begin
                    state_d = S_RESULT;
                end
            end
            default: begin
                // Roll has priority over select, so a simultaneous press keeps the dice type.
                if (roll_edge) begin
                    state_d   = S_ROLLING;
                    value_d   = 7'd1;
                    elapsed_d = EW'(1);
                end else if (sel_edge) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

`ifdef ROLL_ANIM_EN
    logic [11:0] anim_bcd;
    assign anim_bcd    = bin_to_bcd(value_q);
    assign roll_digits = {DIG_BLANK, blank_digits(value_q, anim_bcd[11:8], anim_bcd[7:4], anim_bcd[3:0])};
`else
    assign roll_digits = {DIG_BLANK, DIG_DASH, DIG_DASH, DIG_DASH};
`endif

    always_comb begin
        src = {DIG_BLANK, res_cent_q, res_diz_q, res_unit_q};
        case (state_q)
            S_IDLE:    src = {sep_d, sep_cent, sep_diz, sep_unit};
            S_ROLLING: src = roll_digits;
            default:   ;
        endcase
        digit_d = src[{slot_q, 2'b00} +: 4];
        ps_d    = (ps_q == PS_LAST) ? '0 : ps_q + PW'(1);
        slot_d  = (ps_q == PS_LAST) ? slot_q + 2'd1 : slot_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            dice_q       <= 3'd0;
            value_q      <= 7'd0;
            elapsed_q    <= '0;
            sel_prev_q   <= 1'b0;
            roll_prev_q  <= 1'b0;
            conv_start_q <= 1'b0;
            res_unit_q   <= DIG_BLANK;
            res_diz_q    <= DIG_BLANK;
            res_cent_q   <= DIG_BLANK;
            ps_q         <= '0;
            slot_q       <= 2'd0;
            an_q         <= 4'b1111;
            digit_q      <= DIG_BLANK;
        end else begin
            state_q      <= state_d;
            dice_q       <= dice_d;
            value_q      <= value_d;
            elapsed_q    <= elapsed_d;
            sel_prev_q   <= btn_sel;
            roll_prev_q  <= btn_roll;
            conv_start_q <= (state_d == S_CONV) && (state_q != S_CONV);
            if (conv_done) begin
                {res_cent_q, res_diz_q, res_unit_q} <= blank_digits(value_q, bcd2, bcd1, bcd0);
            end
            ps_q    <= ps_d;
            slot_q  <= slot_d;
            an_q    <= ~(4'b0001 << slot_q);
            digit_q <= digit_d;
        end
    end

    assign dice     = dice_q;
    assign digit    = digit_q;
    assign an       = an_q;
    assign busy     = (state_q == S_ROLLING) || (state_q == S_CONV);
    assign show_res = (state_q == S_RESULT);

endmodule
